// File: rtl/ifmap_unpack_dequant_if.sv
// Handshake bundle for ifmap_unpack_dequant: packed-word input stream and operand output stream.
// The master side is the producer/consumer environment, the slave side is the unpacker.
interface ifmap_unpack_dequant_if #(
  parameter int DATA_BITS = 16
) ();
  logic                        in_valid;
  logic                        in_ready;
  logic [31:0]                 in_data;
  logic [2:0]                  in_bytes;
  logic                        in_last;
  logic                        out_valid;
  logic                        out_ready;
  logic signed [DATA_BITS-1:0] out_data;
  logic                        out_last;

  modport master (
    output in_valid, in_data, in_bytes, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, in_bytes, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/ifmap_unpack_dequant.sv
// Unpacks 32-bit words of uint8 activations, removes the zero point, left-shifts into the PE
// fixed-point domain with saturation and streams one signed operand per cycle.
module ifmap_unpack_dequant #(
  parameter int DATA_BITS = 16
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_flush,
  input  logic [7:0]                  i_zero_point,
  input  logic [3:0]                  i_shift_amt,
  ifmap_unpack_dequant_if.slave       io_bus,
  output logic                        o_tile_done
);

  localparam logic signed [31:0] SatMax = (32'sd1 <<< (DATA_BITS - 1)) - 32'sd1;
  localparam logic signed [31:0] SatMin = -(32'sd1 <<< (DATA_BITS - 1));

  typedef enum logic {StEmpty, StHold} state_e;

  state_e      r_state, w_state_next;
  logic [31:0] r_word, w_word_next;
  logic [2:0]  r_count, w_count_next;
  logic        r_last, w_last_next;
  logic [1:0]  r_idx, w_idx_next;
  logic        r_tile_done, w_tile_done_next;

  logic [2:0]         w_bytes_norm;
  logic [2:0]         w_count_m1;
  logic               w_at_end;
  logic               w_load;
  logic [7:0]         w_byte;
  logic signed [8:0]  w_diff;
  logic signed [31:0] w_prod;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= StEmpty;
      r_word      <= '0;
      r_count     <= '0;
      r_last      <= 1'b0;
      r_idx       <= '0;
      r_tile_done <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_word      <= w_word_next;
      r_count     <= w_count_next;
      r_last      <= w_last_next;
      r_idx       <= w_idx_next;
      r_tile_done <= w_tile_done_next;
    end
  end

  // in_bytes of 0 or above 4 means a full word
  assign w_bytes_norm = (io_bus.in_bytes == 3'd0 || io_bus.in_bytes > 3'd4) ? 3'd4
                                                                            : io_bus.in_bytes;
  assign w_count_m1   = r_count - 3'd1;
  assign w_at_end     = ({1'b0, r_idx} == w_count_m1);

  always_comb begin
    w_state_next     = r_state;
    w_word_next      = r_word;
    w_count_next     = r_count;
    w_last_next      = r_last;
    w_idx_next       = r_idx;
    w_tile_done_next = 1'b0;
    w_load           = 1'b0;
    io_bus.in_ready  = 1'b0;

    if (i_flush) begin
      w_state_next = StEmpty;
      w_idx_next   = '0;
    end else begin
      unique case (r_state)
        StEmpty: begin
          io_bus.in_ready = 1'b1;
          w_load          = io_bus.in_valid;
        end
        StHold: begin
          if (io_bus.out_ready) begin
            w_tile_done_next = r_last && w_at_end;
            if (!w_at_end) begin
              w_idx_next = r_idx + 2'd1;
            end else begin
              // Last byte leaves this cycle: chain the next word without a bubble
              io_bus.in_ready = 1'b1;
              if (io_bus.in_valid) begin
                w_load = 1'b1;
              end else begin
                w_state_next = StEmpty;
              end
            end
          end
        end
        default: w_state_next = StEmpty;
      endcase
    end

    if (w_load) begin
      w_state_next = StHold;
      w_word_next  = io_bus.in_data;
      w_count_next = w_bytes_norm;
      w_last_next  = io_bus.in_last;
      w_idx_next   = '0;
    end
  end

  assign w_byte = r_word[{r_idx, 3'b000} +: 8];
  assign w_diff = $signed({1'b0, w_byte}) - $signed({1'b0, i_zero_point});
  assign w_prod = {{23{w_diff[8]}}, w_diff} <<< i_shift_amt;

  always_comb begin
    if (w_prod > SatMax) begin
      io_bus.out_data = SatMax[DATA_BITS-1:0];
    end else if (w_prod < SatMin) begin
      io_bus.out_data = SatMin[DATA_BITS-1:0];
    end else begin
      io_bus.out_data = w_prod[DATA_BITS-1:0];
    end
  end

  assign io_bus.out_valid = (r_state == StHold);
  assign io_bus.out_last  = (r_state == StHold) && r_last && w_at_end;
  assign o_tile_done      = r_tile_done;

endmodule

// File: tb/tb_ifmap_unpack_dequant.sv
// Scoreboard bench for ifmap_unpack_dequant: directed words push hand-computed operands,
// a negedge monitor pops and compares on every output handshake.
module tb_ifmap_unpack_dequant;

  typedef struct {
    int data;
    bit last;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic [7:0] zp;
  logic [3:0] sh;
  logic       tile_done;
  int         cyc;
  int         n_cmp;
  int         n_err;
  int         last_hs_cyc;
  bit         bp_en;

  exp_t exp_q[$];

  ifmap_unpack_dequant_if #(.DATA_BITS(16)) bus ();

  ifmap_unpack_dequant #(.DATA_BITS(16)) u_dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_flush      (flush),
    .i_zero_point (zp),
    .i_shift_amt  (sh),
    .io_bus       (bus),
    .o_tile_done  (tile_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic signed [31:0] act,
                     input logic signed [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: tile_done tracking, stall stability and scoreboard pops
  bit                 pend;
  bit                 held_v;
  logic signed [31:0] held_d;
  logic               held_l;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      pend   = 1'b0;
      held_v = 1'b0;
    end else begin
      chk("tile_done", 32'(tile_done), 32'(pend));
      if (held_v) begin
        chk("hold_valid", 32'(bus.out_valid), 32'sd1);
        chk("hold_data", 32'(bus.out_data), held_d);
        chk("hold_last", 32'(bus.out_last), 32'(held_l));
      end
      pend = 1'b0;
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_operand: got %0d, expected none", $signed(bus.out_data));
        end else begin
          e = exp_q.pop_front();
          chk("operand", 32'(bus.out_data), e.data);
          chk("operand_last", 32'(bus.out_last), 32'(e.last));
          pend        = e.last;
          last_hs_cyc = cyc;
        end
      end
      held_v = bus.out_valid && !bus.out_ready && !flush;
      held_d = 32'(bus.out_data);
      held_l = bus.out_last;
    end
  end

  // Back-pressure pattern 1,0,0,1 applied after each rising edge while enabled
  initial begin
    int k = 0;
    forever begin
      @(posedge clk);
      #1;
      if (bp_en) begin
        bus.out_ready = (k % 4 == 0) || (k % 4 == 3);
        k++;
      end
    end
  end

  task automatic send_word(input logic [31:0] d, input logic [2:0] b, input logic l,
                           input int n, input int e0, input int e1, input int e2, input int e3);
    int  ex[4];
    bit  acc;
    int  t;
    ex = '{e0, e1, e2, e3};
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_bytes = b;
    bus.in_last  = l;
    acc = 1'b0;
    t   = 0;
    while (!acc && t < 50) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      t++;
    end
    bus.in_valid = 1'b0;
    if (!acc) begin
      chk("accept_timeout", 32'sd0, 32'sd1);
    end else begin
      for (int i = 0; i < n; i++) exp_q.push_back('{data: ex[i], last: (l && i == n - 1)});
    end
  endtask

  task automatic wait_drain();
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while ((exp_q.size() != 0 || bus.out_valid) && t < 300);
    if (t >= 300) chk("drain_timeout", 32'sd0, 32'sd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cyc_a;
    n_cmp = 0;
    n_err = 0;
    cyc   = 0;
    bp_en = 1'b0;
    rst_n = 1'b0;
    flush = 1'b0;
    zp    = 8'd128;
    sh    = 4'd8;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_bytes  = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'sd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'sd0);
    chk("rst_out_last", 32'(bus.out_last), 32'sd0);
    chk("rst_tile_done", 32'(tile_done), 32'sd0);
    @(posedge clk);
    #1;

    // Single word, zp=128, shift=8
    bus.out_ready = 1'b1;
    send_word(32'h0080FF81, 3'd4, 1'b0, 4, 256, 32512, 0, -32768);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("word_in_ready", 32'(bus.in_ready), (i == 3) ? 32'sd1 : 32'sd0);
      chk("word_out_valid", 32'(bus.out_valid), 32'sd1);
      @(posedge clk);
      #1;
    end
    wait_drain();

    // Saturation corners
    zp = 8'd255; sh = 4'd8;
    send_word(32'h00000000, 3'd1, 1'b0, 1, -32768, 0, 0, 0);
    wait_drain();
    zp = 8'd0;
    send_word(32'h000000FF, 3'd1, 1'b0, 1, 32767, 0, 0, 0);
    wait_drain();
    sh = 4'd0;
    send_word(32'h000000FF, 3'd1, 1'b0, 1, 255, 0, 0, 0);
    wait_drain();

    // Partial last word, then in_bytes=0 as a full word
    zp = 8'd128; sh = 4'd0;
    send_word(32'hAAAA0583, 3'd2, 1'b1, 2, 3, -123, 0, 0);
    wait_drain();
    send_word(32'h04030201, 3'd0, 1'b0, 4, -127, -126, -125, -124);
    wait_drain();

    // Back-to-back without stalls: 8 operands on 8 consecutive cycles
    send_word(32'h84838281, 3'd4, 1'b0, 4, 1, 2, 3, 4);
    cyc_a = cyc;
    send_word(32'h88878685, 3'd4, 1'b1, 4, 5, 6, 7, 8);
    wait_drain();
    chk("no_bubble", last_hs_cyc - cyc_a, 32'sd7);

    // Back-pressure across two words
    bp_en = 1'b1;
    send_word(32'h8C8B8A89, 3'd4, 1'b0, 4, 9, 10, 11, 12);
    send_word(32'h7F7E7D7C, 3'd3, 1'b1, 3, -4, -3, -2, 0);
    wait_drain();
    bp_en = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;

    // Flush at idx=2 with a competing word on the input
    send_word(32'h14131211, 3'd4, 1'b0, 2, -111, -110, 0, 0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    flush = 1'b1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'h99999999;
    bus.in_bytes  = 3'd4;
    bus.in_last   = 1'b0;
    @(negedge clk);
    chk("flush_in_ready", 32'(bus.in_ready), 32'sd0);
    chk("flush_idx2_data", 32'(bus.out_data), -32'sd109);
    @(posedge clk);
    #1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", 32'(bus.out_valid), 32'sd0);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    send_word(32'h24232221, 3'd4, 1'b0, 4, -95, -94, -93, -92);
    wait_drain();

    // Async reset while tile_done is high
    send_word(32'h000000FF, 3'd1, 1'b1, 1, 127, 0, 0, 0);
    @(posedge clk);
    #2;
    chk("pre_rst_tile_done", 32'(tile_done), 32'sd1);
    rst_n = 1'b0;
    #1;
    chk("rst_drop_tile_done", 32'(tile_done), 32'sd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    exp_q.delete();

    // Async reset while a word is stalled mid-way
    bus.out_ready = 1'b0;
    send_word(32'h34333231, 3'd4, 1'b0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #2;
    chk("pre_rst_out_valid", 32'(bus.out_valid), 32'sd1);
    rst_n = 1'b0;
    #1;
    chk("rst_drop_out_valid", 32'(bus.out_valid), 32'sd0);
    chk("rst_drop_out_last", 32'(bus.out_last), 32'sd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_out_valid", 32'(bus.out_valid), 32'sd0);
    end
    @(posedge clk);
    #1;
    chk("queue_empty", exp_q.size(), 32'sd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
